// File: rtl/mant_align_shift_if.sv
// mant_align_shift_if: valid/ready input and output channels of the mantissa alignment shifter.
interface mant_align_shift_if #(
  parameter int num_round_bits = 8,
  parameter int exp_width = 8,
  parameter int mant_width = 23
);
  localparam int W = mant_width + num_round_bits + 1;
  logic in_valid;
  logic in_ready;
  logic [mant_width:0] in_mant;
  logic [exp_width+1:0] in_shamt;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_mant;
  logic out_sticky;
  logic out_zero;
  modport slave (
    input in_valid, in_mant, in_shamt, out_ready,
    output in_ready, out_valid, out_mant, out_sticky, out_zero
  );
  modport master (
    output in_valid, in_mant, in_shamt, out_ready,
    input in_ready, out_valid, out_mant, out_sticky, out_zero
  );
endinterface

// File: rtl/mant_align_shift.sv
// mant_align_shift: two-stage right alignment shifter (coarse by 8s, then fine 0..7) with sticky tracking.
// Sticky logic is built only when ALIGN_STICKY_EN is defined; otherwise out_sticky is 0.
module mant_align_shift #(
  parameter int num_round_bits = 8,
  parameter int exp_width = 8,
  parameter int mant_width = 23
) (
  input logic clk,
  input logic rst,
  mant_align_shift_if.slave io
);
  localparam int W = mant_width + num_round_bits + 1;
  localparam int SW = exp_width + 2;
  localparam logic [SW-1:0] W_S = SW'(W);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [W-1:0] s1_val_q, s1_val_d, s2_mant_q, s2_mant_d;
  logic [2:0] s1_fine_q, s1_fine_d;
  logic s1_sticky_q, s1_sticky_d, s2_sticky_q, s2_sticky_d, s2_zero_q, s2_zero_d;
  logic s1_adv, in_rdy, in_fire, s1_fire, sat, lost1, lost2;
  logic [W-1:0] work, coarse_val, fine_val;
  logic [SW-1:0] coarse;
  always_comb begin
    s1_adv = !s2_valid_q || io.out_ready;
    in_rdy = !s1_valid_q || s1_adv;
    in_fire = io.in_valid && in_rdy;
    s1_fire = s1_valid_q && s1_adv;
    work = {io.in_mant, {num_round_bits{1'b0}}};
    coarse = {io.in_shamt[SW-1:3], 3'b000};
    sat = io.in_shamt >= W_S;
    coarse_val = sat ? '0 : work >> coarse;
    fine_val = s1_val_q >> s1_fine_q;
`ifdef ALIGN_STICKY_EN
    lost1 = sat ? |io.in_mant : |(work & ~({W{1'b1}} << coarse));
    lost2 = s1_sticky_q || (|(s1_val_q & ~({W{1'b1}} << s1_fine_q)));
`else
    lost1 = 1'b0;
    lost2 = 1'b0;
`endif
    s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
    s1_val_d = in_fire ? coarse_val : s1_val_q;
    s1_fine_d = in_fire ? (sat ? 3'd0 : io.in_shamt[2:0]) : s1_fine_q;
    s1_sticky_d = in_fire ? lost1 : s1_sticky_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    s2_mant_d = s1_fire ? fine_val : s2_mant_q;
    s2_sticky_d = s1_fire ? lost2 : s2_sticky_q;
    s2_zero_d = s1_fire ? (fine_val == '0) : s2_zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_val_q <= '0;
      s1_fine_q <= '0;
      s1_sticky_q <= 1'b0;
      s2_mant_q <= '0;
      s2_sticky_q <= 1'b0;
      s2_zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_val_q <= s1_val_d;
      s1_fine_q <= s1_fine_d;
      s1_sticky_q <= s1_sticky_d;
      s2_mant_q <= s2_mant_d;
      s2_sticky_q <= s2_sticky_d;
      s2_zero_q <= s2_zero_d;
    end
  end
  assign io.in_ready = in_rdy;
  assign io.out_valid = s2_valid_q;
  assign io.out_mant = s2_mant_q;
  assign io.out_sticky = s2_sticky_q;
  assign io.out_zero = s2_zero_q;
endmodule

// File: doc/mant_align_shift.md
Name: mant_align_shift

Overview:
- Pipelined right-shift alignment unit for the FPU add path. It is the counterpart of the leading-zero counter: the counter measures a left normalisation shift, this block applies a right alignment shift.
- Takes the smaller operand's mantissa (hidden bit included) and the exponent difference, and shifts it right into a mantissa-plus-round-bits field. That field has the same width the leading-zero counter consumes.
- Tracks bits lost below the round field.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- num_round_bits, 8, number of extra round bits kept below the mantissa LSB (the stochastic-rounding field).
- exp_width, 8, exponent width; the shift amount is exp_width+2 bits.
- mant_width, 23, stored mantissa width; the input is mant_width+1 bits including the hidden bit.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat this cycle.
- in_mant  input  mant_width+1  mantissa with hidden bit at the MSB.
- in_shamt  input  exp_width+2  unsigned right-shift amount (exponent difference).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_mant  output  mant_width+num_round_bits+1  aligned mantissa and round bits.
- out_sticky  output  1  OR of all bits shifted below the out_mant LSB.
- out_zero  output  1  out_mant is all zero.

Behaviour:
- Definitions: W = mant_width+num_round_bits+1. The working value is {in_mant, num_round_bits zeros}, W bits wide.
- Transfers: a beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
- Stage advance: s1_adv = !s2_valid || out_ready. in_ready = !s1_valid || s1_adv. Both are combinational; in_ready does not depend on in_valid.
- Stage 1 (coarse shift), on input transfer:
  - If in_shamt >= W: register value 0, sticky1 = |in_mant, and set sat.
  - Otherwise: shift the working value right by {in_shamt[hi:3], 3'b000}. sticky1 = OR of the bits lost. Register the fine amount in_shamt[2:0].
- Stage 2 (fine shift), on s1_adv && s1_valid:
  - Shift the stage-1 value right by the fine amount (0..7).
  - out_sticky = sticky1 OR the bits lost in this shift.
  - out_zero = (result == 0).
  - Load out_mant, out_sticky and out_zero from stage-2 registers.
- Latency: exactly 2 cycles from input transfer to out_valid with no back-pressure. Throughput is 1 beat per cycle.
- Valid flags:
  - s1_valid is set on input transfer and cleared when stage 1 advances with no new input.
  - s2_valid (which drives out_valid) is set when stage 1 advances and cleared on an output transfer with no incoming beat.
- Stall: while out_valid && !out_ready, out_mant, out_sticky and out_zero hold stable. Stage 1 holds once it is full. At most 2 beats are in flight. Order is preserved and no beat is dropped or duplicated.
- Simultaneous events: output transfer and stage-1 advance in the same cycle replace the stage-2 contents with no bubble.
- Boundaries:
  - in_shamt = 0 passes the value unshifted with sticky 0.
  - in_shamt = W-1 leaves only the hidden bit position at the out_mant LSB.
  - Any in_shamt >= W (up to the maximum 2^(exp_width+2)-1) gives out_mant 0 and out_zero 1.
  - in_mant = 0 gives out_mant 0, sticky 0, zero 1 for any shift.
- Reset (asynchronous, any time, including mid-operation):
  - s1_valid = 0, s2_valid = 0, out_valid = 0, out_mant = 0, out_sticky = 0, out_zero = 0.
  - in_ready reads 1 after reset.
  - In-flight beats are discarded; no stale beat appears after reset deasserts.

Optional Feature:
- Macro ALIGN_STICKY_EN.
- Defined: sticky is computed as above.
- Undefined: no sticky logic is built. Bits below the out_mant LSB are truncated (pure stochastic-rounding path), and out_sticky is tied to 0. All other behaviour, including latency, is unchanged.

Test Plan (default parameters, W=32, ALIGN_STICKY_EN defined unless noted):
- in_mant=0xC00001, in_shamt=0 -> 2 cycles later out_mant=0xC0000100, sticky=0, zero=0.
- in_mant=0x800001, in_shamt=9 -> out_mant=0x00400000, sticky=1. With the macro undefined: same out_mant, sticky=0.
- in_mant=0x800000, in_shamt=40 (saturated), then in_mant=0, in_shamt=5 -> first beat out_mant=0, sticky=1, zero=1; second beat out_mant=0, sticky=0, zero=1.
- 4 back-to-back beats with out_ready low for 3 cycles -> in_ready drops after 2 accepted, out_mant held stable during the stall, all 4 beats emerge in order with no gaps once out_ready returns high.
- Continuous streaming, 100 random beats with random out_ready -> every output matches a reference model computed as (value >> shamt) plus OR of lost bits.
- Assert rst with both stages valid -> out_valid=0 immediately without waiting for a clock edge. After release, no output beat appears until a new input transfer.
